// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state and byte-class enums, and the data-byte count helper.
package midi_pkg;

  localparam logic [7:0] ST_NOTE_OFF   = 8'h80;
  localparam logic [7:0] ST_NOTE_ON    = 8'h90;
  localparam logic [7:0] ST_POLY_AT    = 8'hA0;
  localparam logic [7:0] ST_CTRL       = 8'hB0;
  localparam logic [7:0] ST_PROG       = 8'hC0;
  localparam logic [7:0] ST_CHAN_AT    = 8'hD0;
  localparam logic [7:0] ST_PITCH      = 8'hE0;
  localparam logic [7:0] ST_SYSEX      = 8'hF0;
  localparam logic [7:0] ST_MTC        = 8'hF1;
  localparam logic [7:0] ST_SONG_POS   = 8'hF2;
  localparam logic [7:0] ST_SONG_SEL   = 8'hF3;
  localparam logic [7:0] ST_TUNE       = 8'hF6;
  localparam logic [7:0] ST_SYSEX_END  = 8'hF7;
  localparam logic [7:0] ST_RT_CLOCK   = 8'hF8;
  localparam logic [7:0] ST_RT_RESET   = 8'hFF;

  localparam logic [6:0] NOTEON_V0_VELOCITY = 7'h40;

  typedef enum logic [1:0] {
    S_NONE,
    S_D1,
    S_D2,
    S_SYSEX
  } parse_state_t;

  typedef enum logic [2:0] {
    BC_DATA,
    BC_VOICE,
    BC_COMMON,
    BC_SYSEX_START,
    BC_SYSEX_END,
    BC_REALTIME,
    BC_UNDEF
  } byte_class_t;

  function automatic logic [1:0] midi_data_count(input logic [7:0] status);
    logic [1:0] cnt;
    cnt = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: cnt = 2'd2;
      4'hC, 4'hD:                   cnt = 2'd1;
      4'hF: begin
        if (status == ST_MTC || status == ST_SONG_SEL) cnt = 2'd1;
        else if (status == ST_SONG_POS)                cnt = 2'd2;
        else                                           cnt = 2'd0;
      end
      default:                      cnt = 2'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/midi_status_decode.sv
// Combinational classifier: raw MIDI byte -> byte class and number of data bytes it expects.
module midi_status_decode
  import midi_pkg::*;
(
  input  logic [7:0]  byte_in,
  output byte_class_t byte_class,
  output logic [1:0]  data_count
);

  always_comb begin
    byte_class = BC_UNDEF;
    if (!byte_in[7])                     byte_class = BC_DATA;
    else if (byte_in < ST_SYSEX)         byte_class = BC_VOICE;
    else if (byte_in == ST_SYSEX)        byte_class = BC_SYSEX_START;
    else if (byte_in == ST_SYSEX_END)    byte_class = BC_SYSEX_END;
    else if (byte_in >= ST_RT_CLOCK)     byte_class = BC_REALTIME;
    else if (byte_in == ST_MTC || byte_in == ST_SONG_POS ||
             byte_in == ST_SONG_SEL || byte_in == ST_TUNE)
                                         byte_class = BC_COMMON;
    else                                 byte_class = BC_UNDEF;
  end

  assign data_count = midi_data_count(byte_in);

endmodule

// File: rtl/midi_msg_parser.sv
// Assembles MIDI messages (running status, realtime interleave, SysEx skip) into a one-entry
// valid/ready output slot with orphan and overflow error pulses.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter logic [15:0] CHANNEL_MASK      = 16'hFFFF,
  parameter bit          CONVERT_NOTEON_V0 = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       msg_valid,
  input  logic       msg_ready,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       err_overflow,
  output logic       err_orphan
);

  byte_class_t  byte_class;
  logic [1:0]   data_count;

  parse_state_t state, state_n;
  logic [7:0]   cur_status, cur_status_n;
  logic [1:0]   need, need_n;
  logic [6:0]   data1, data1_n;

  logic         emit;
  logic [7:0]   em_status;
  logic [6:0]   em_d1, em_d2;
  logic [1:0]   em_len;
  logic         orphan;

  logic         out_emit;
  logic [7:0]   out_status;
  logic [6:0]   out_d2;
  logic         cur_is_voice;

  midi_status_decode u_decode (
    .byte_in    (byte_in),
    .byte_class (byte_class),
    .data_count (data_count)
  );

  assign cur_is_voice = (cur_status[7:4] != 4'hF) && cur_status[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_NONE;
      cur_status <= '0;
      need       <= '0;
      data1      <= '0;
    end else begin
      state      <= state_n;
      cur_status <= cur_status_n;
      need       <= need_n;
      data1      <= data1_n;
    end
  end

  always_comb begin
    state_n      = state;
    cur_status_n = cur_status;
    need_n       = need;
    data1_n      = data1;
    emit         = 1'b0;
    em_status    = '0;
    em_d1        = '0;
    em_d2        = '0;
    em_len       = '0;
    orphan       = 1'b0;
    if (byte_valid) begin
      case (byte_class)
        BC_VOICE: begin
          cur_status_n = byte_in;
          need_n       = data_count;
          state_n      = S_D1;
        end
        BC_COMMON: begin
          if (data_count == 2'd0) begin
            emit         = 1'b1;
            em_status    = byte_in;
            em_len       = 2'd1;
            cur_status_n = '0;
            state_n      = S_NONE;
          end else begin
            // Held only for this message; returns to S_NONE after it completes.
            cur_status_n = byte_in;
            need_n       = data_count;
            state_n      = S_D1;
          end
        end
        BC_SYSEX_START: begin
          cur_status_n = '0;
          state_n      = S_SYSEX;
        end
        BC_SYSEX_END, BC_UNDEF: begin
          cur_status_n = '0;
          state_n      = S_NONE;
        end
        BC_REALTIME: begin
          emit      = 1'b1;
          em_status = byte_in;
          em_len    = 2'd1;
        end
        BC_DATA: begin
          case (state)
            S_NONE: orphan = 1'b1;
            S_D1: begin
              data1_n = byte_in[6:0];
              if (need == 2'd1) begin
                emit      = 1'b1;
                em_status = cur_status;
                em_d1     = byte_in[6:0];
                em_len    = 2'd2;
                if (!cur_is_voice) begin
                  cur_status_n = '0;
                  state_n      = S_NONE;
                end
              end else begin
                state_n = S_D2;
              end
            end
            S_D2: begin
              emit      = 1'b1;
              em_status = cur_status;
              em_d1     = data1;
              em_d2     = byte_in[6:0];
              em_len    = 2'd3;
              if (cur_is_voice) begin
                state_n = S_D1;
              end else begin
                cur_status_n = '0;
                state_n      = S_NONE;
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Channel filter and Note-On velocity-0 rewrite applied to the completed message.
  always_comb begin
    out_emit   = emit;
    out_status = em_status;
    out_d2     = em_d2;
    if (emit && em_status[7:4] != 4'hF) begin
      if (!CHANNEL_MASK[em_status[3:0]]) out_emit = 1'b0;
      if (CONVERT_NOTEON_V0 && em_status[7:4] == 4'h9 && em_len == 2'd3 && em_d2 == 7'd0) begin
        out_status = {4'h8, em_status[3:0]};
        out_d2     = NOTEON_V0_VELOCITY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msg_valid    <= 1'b0;
      msg_status   <= '0;
      msg_data1    <= '0;
      msg_data2    <= '0;
      msg_len      <= '0;
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      err_orphan   <= orphan;
      err_overflow <= 1'b0;
      if (out_emit && (!msg_valid || msg_ready)) begin
        msg_valid  <= 1'b1;
        msg_status <= out_status;
        msg_data1  <= em_d1;
        msg_data2  <= out_d2;
        msg_len    <= em_len;
      end else begin
        if (out_emit) err_overflow <= 1'b1;
        if (msg_valid && msg_ready) msg_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed tests for midi_msg_parser: default instance plus a channel-0-only instance.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       msg_ready;

  logic       msg_valid, err_overflow, err_orphan;
  logic [7:0] msg_status;
  logic [6:0] msg_data1, msg_data2;
  logic [1:0] msg_len;

  logic       m_valid, m_overflow, m_orphan;
  logic [7:0] m_status;
  logic [6:0] m_data1, m_data2;
  logic [1:0] m_len;

  int passed = 0;
  int total  = 0;

  logic [24:0] mv;
  assign mv = {msg_valid, msg_status, msg_data1, msg_data2, msg_len};

  always #10 clk = ~clk;

  midi_msg_parser dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_status(msg_status),
    .msg_data1(msg_data1), .msg_data2(msg_data2), .msg_len(msg_len),
    .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  midi_msg_parser #(.CHANNEL_MASK(16'h0001), .CONVERT_NOTEON_V0(1'b1)) dut_m (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
    .msg_valid(m_valid), .msg_ready(msg_ready), .msg_status(m_status),
    .msg_data1(m_data1), .msg_data2(m_data2), .msg_len(m_len),
    .err_overflow(m_overflow), .err_orphan(m_orphan)
  );

  // Strobe one byte; returns #1 after the edge that captured it.
  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; byte_in = '0; byte_valid = 1'b0; msg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (mv !== 25'd0 || err_overflow !== 1'b0 || err_orphan !== 1'b0)
      $display("FAIL reset_outputs got msg=%h ovf=%b orph=%b want 0", mv, err_overflow, err_orphan);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_single;
    send(8'h90); send(8'h3C);
    total++;
    if (msg_valid !== 1'b0) $display("FAIL single_early got valid=%b want 0", msg_valid);
    else passed++;
    send(8'h64);
    total++;
    if (mv !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3})
      $display("FAIL single_msg got %h want %h", mv, {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3});
    else passed++;
    msg_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (msg_valid !== 1'b0) $display("FAIL single_accept got valid=%b want 0", msg_valid);
    else passed++;
  endtask

  task automatic test_running_status;
    send(8'h3E); send(8'h50);
    total++;
    if (mv !== {1'b1, 8'h90, 7'h3E, 7'h50, 2'd3})
      $display("FAIL rs_note got %h want %h", mv, {1'b1, 8'h90, 7'h3E, 7'h50, 2'd3});
    else passed++;
    send(8'hC5); send(8'h07);
    total++;
    if (mv !== {1'b1, 8'hC5, 7'h07, 7'h00, 2'd2})
      $display("FAIL rs_prog1 got %h want %h", mv, {1'b1, 8'hC5, 7'h07, 7'h00, 2'd2});
    else passed++;
    send(8'h08);
    total++;
    if (mv !== {1'b1, 8'hC5, 7'h08, 7'h00, 2'd2})
      $display("FAIL rs_prog2 got %h want %h", mv, {1'b1, 8'hC5, 7'h08, 7'h00, 2'd2});
    else passed++;
  endtask

  task automatic test_realtime;
    send(8'h90); send(8'h3C); send(8'hF8);
    total++;
    if (mv !== {1'b1, 8'hF8, 7'h00, 7'h00, 2'd1})
      $display("FAIL rt_clock got %h want %h", mv, {1'b1, 8'hF8, 7'h00, 7'h00, 2'd1});
    else passed++;
    send(8'h64);
    total++;
    if (mv !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3} || err_orphan !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL rt_resume got %h orph=%b ovf=%b want %h no errors", mv, err_orphan,
               err_overflow, {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3});
    else passed++;
  endtask

  task automatic test_sysex;
    logic [7:0] seq [5];
    int unsigned nvalid;
    seq = '{8'h90, 8'hF0, 8'h7E, 8'h01, 8'hF7};
    nvalid = 0;
    foreach (seq[i]) begin
      send(seq[i]);
      if (msg_valid || err_orphan) nvalid++;
    end
    total++;
    if (nvalid !== 0) $display("FAIL sysex_quiet got %0d events want 0", nvalid);
    else passed++;
    send(8'h3C);
    total++;
    if (err_orphan !== 1'b1 || msg_valid !== 1'b0)
      $display("FAIL sysex_orphan got orph=%b valid=%b want 1/0", err_orphan, msg_valid);
    else passed++;
    @(posedge clk); #1;
    total++;
    if (err_orphan !== 1'b0) $display("FAIL orphan_pulse got %b want 0", err_orphan);
    else passed++;
  endtask

  task automatic test_backpressure;
    msg_ready = 1'b0;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h80); send(8'h3C);
    total++;
    if (mv !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3})
      $display("FAIL bp_hold got %h want %h", mv, {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3});
    else passed++;
    send(8'h00);
    total++;
    if (err_overflow !== 1'b1 || mv !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3})
      $display("FAIL bp_overflow got ovf=%b msg=%h want 1 %h", err_overflow, mv,
               {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3});
    else passed++;
    msg_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (msg_valid !== 1'b0 || err_overflow !== 1'b0)
      $display("FAIL bp_drain got valid=%b ovf=%b want 0/0", msg_valid, err_overflow);
    else passed++;
  endtask

  task automatic test_params;
    send(8'h93); send(8'h40); send(8'h00);
    total++;
    if (mv !== {1'b1, 8'h83, 7'h40, 7'h40, 2'd3})
      $display("FAIL noteon_v0 got %h want %h", mv, {1'b1, 8'h83, 7'h40, 7'h40, 2'd3});
    else passed++;
    send(8'h91); send(8'h3C); send(8'h64);
    total++;
    if (m_valid !== 1'b0 || m_orphan !== 1'b0 || m_overflow !== 1'b0)
      $display("FAIL mask_drop got valid=%b orph=%b ovf=%b want 0", m_valid, m_orphan, m_overflow);
    else passed++;
    total++;
    if (mv !== {1'b1, 8'h91, 7'h3C, 7'h64, 2'd3})
      $display("FAIL mask_default got %h want %h", mv, {1'b1, 8'h91, 7'h3C, 7'h64, 2'd3});
    else passed++;
    send(8'h90); send(8'h3C); send(8'h64);
    total++;
    if ({m_valid, m_status, m_data1, m_data2, m_len} !== {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3})
      $display("FAIL mask_ch0 got %h want %h", {m_valid, m_status, m_data1, m_data2, m_len},
               {1'b1, 8'h90, 7'h3C, 7'h64, 2'd3});
    else passed++;
  endtask

  task automatic test_reset_mid;
    send(8'h90); send(8'h3C);
    #3 rst = 1'b1;
    #2;
    total++;
    if (mv !== 25'd0) $display("FAIL rst_async got %h want 0", mv);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    send(8'h64);
    total++;
    if (err_orphan !== 1'b1 || msg_valid !== 1'b0)
      $display("FAIL rst_orphan got orph=%b valid=%b want 1/0", err_orphan, msg_valid);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_running_status;
    test_realtime;
    test_sysex;
    test_backpressure;
    test_params;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
